// File: rtl/dpr_ctrl_pkg.sv
// dpr_ctrl_pkg -- shared state encoding, error codes and status-LED pattern for dpr_region_ctrl
// Rev 1.0
`default_nettype none

package dpr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECOUPLE = 3'd1,
    ST_PROGRAM  = 3'd2,
    ST_RESET_RM = 3'd3,
    ST_RELEASE  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LOADER  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // Status pattern shown on the pins while the region is isolated:
  // MSB marks "region offline", the two LSBs carry the last error code.
  function automatic logic [31:0] status_leds(input int led_w, input logic [1:0] err);
    logic [31:0] pat;
    pat = 32'd0;
    pat[led_w-1] = 1'b1;
    pat[1:0] = err;
    return pat;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dpr_cycle_timer.sv
// dpr_cycle_timer -- loadable down-counter with a one-cycle expiry strobe
// Rev 1.0
`default_nettype none

module dpr_cycle_timer #(
  parameter int              CNT_W     = 20,
  parameter logic [CNT_W-1:0] RST_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RST_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - ONE;
    end
  end

  // A load of N therefore gives exactly N enabled cycles, the last one flagged.
  assign expired = enable && (count == ONE);

endmodule

`default_nettype wire

// File: rtl/dpr_region_ctrl.sv
// dpr_region_ctrl -- sequences RM swaps in the DPR region (decouple, load, reset, recouple)
// Rev 1.0 -- optional status pattern on leds while decoupled: define DPR_STATUS_LEDS_EN
`default_nettype none

module dpr_region_ctrl
  import dpr_ctrl_pkg::*;
#(
  parameter int RM_ID_W         = 4,
  parameter int LED_W           = 8,
  parameter int DECOUPLE_CYCLES = 4,
  parameter int RESET_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [RM_ID_W-1:0] req_rm_id,
  output logic               req_ready,
  output logic               done,
  output logic [1:0]         err_code,
  output logic               active_valid,
  output logic [RM_ID_W-1:0] active_rm_id,
  output logic               pr_start,
  output logic [RM_ID_W-1:0] pr_rm_id,
  input  logic               pr_done,
  input  logic               pr_error,
  output logic               decouple,
  output logic               rm_rst,
  input  logic [LED_W-1:0]   rm_leds,
  output logic [LED_W-1:0]   leds
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEC_LOAD = CNT_W'(DECOUPLE_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RESET_CYCLES);

  state_t             state;
  state_t             state_next;
  logic [RM_ID_W-1:0] target_id;
  logic               post_reset;
  logic [LED_W-1:0]   leds_q;
  logic               accept;
  logic               same_rm;
  logic               prog_fail;
  logic               tmr_load;
  logic               tmr_en;
  logic               tmr_expired;
  logic [CNT_W-1:0]   tmr_value;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_ready && req_valid;
  assign same_rm   = active_valid && (req_rm_id == active_rm_id);
  assign pr_rm_id  = target_id;

  // pr_error wins over a coincident pr_done; pr_done wins over expiry.
  assign prog_fail = (state == ST_PROGRAM) && (pr_error || (!pr_done && tmr_expired));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (accept && !same_rm) state_next = ST_DECOUPLE;
      ST_DECOUPLE: if (tmr_expired) state_next = ST_PROGRAM;
      ST_PROGRAM: begin
        if (prog_fail)    state_next = ST_IDLE;
        else if (pr_done) state_next = ST_RESET_RM;
      end
      ST_RESET_RM: if (tmr_expired) state_next = ST_RELEASE;
      ST_RELEASE:  state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tmr_value = '0;
    case (state_next)
      ST_DECOUPLE: tmr_value = DEC_LOAD;
      ST_PROGRAM:  tmr_value = TMO_LOAD;
      ST_RESET_RM: tmr_value = RST_LOAD;
      default:     tmr_value = '0;
    endcase
  end

  assign tmr_load = (state_next != state);
  assign tmr_en   = (state == ST_DECOUPLE) || (state == ST_PROGRAM) || (state == ST_RESET_RM);

  dpr_cycle_timer #(
    .CNT_W     (CNT_W),
    .RST_VALUE (RST_LOAD)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (tmr_value),
    .enable     (tmr_en),
    .expired    (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RESET_RM;
      decouple     <= 1'b1;
      rm_rst       <= 1'b1;
      pr_start     <= 1'b0;
      done         <= 1'b0;
      err_code     <= ERR_NONE;
      active_valid <= 1'b0;
      active_rm_id <= '0;
      target_id    <= '0;
      post_reset   <= 1'b1;
    end else begin
      state    <= state_next;
      pr_start <= (state == ST_DECOUPLE) && (state_next == ST_PROGRAM);
      rm_rst   <= (state_next == ST_RESET_RM);
      done     <= 1'b0;

      if (state_next == ST_DECOUPLE) begin
        decouple <= 1'b1;
      end else if (state_next == ST_RELEASE) begin
        decouple <= 1'b0;
      end

      if (accept) begin
        err_code <= ERR_NONE;
        if (same_rm) begin
          done <= 1'b1;
        end else begin
          target_id <= req_rm_id;
        end
      end

      // Failure leaves the region isolated; decouple simply stays set.
      if (prog_fail) begin
        err_code     <= pr_error ? ERR_LOADER : ERR_TIMEOUT;
        active_valid <= 1'b0;
        done         <= 1'b1;
      end

      if (state_next == ST_RELEASE) begin
        active_valid <= 1'b1;
        active_rm_id <= target_id;
        done         <= !post_reset;
        post_reset   <= 1'b0;
      end
    end
  end

  // Capture only while coupled, so the last good value survives decoupling.
  always_ff @(posedge clk) begin
    if (rst) begin
      leds_q <= '0;
    end else if (!decouple) begin
      leds_q <= rm_leds;
    end
  end

`ifdef DPR_STATUS_LEDS_EN
  logic [31:0] status_word;
  assign status_word = status_leds(LED_W, err_code);
  assign leds = decouple ? status_word[LED_W-1:0] : leds_q;
`else
  assign leds = leds_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dpr_region_ctrl.sv
// tb_dpr_region_ctrl -- randomized scoreboard bench for dpr_region_ctrl (TIMEOUT_CYCLES=100)
// Rev 1.0
`default_nettype none

module tb_dpr_region_ctrl;

  localparam int RM_ID_W = 4;
  localparam int LED_W   = 8;
  localparam int DEC     = 4;
  localparam int RSTC    = 16;
  localparam int TMO     = 100;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               req_valid = 1'b0;
  logic [RM_ID_W-1:0] req_rm_id = '0;
  logic               pr_done = 1'b0;
  logic               pr_error = 1'b0;
  logic [LED_W-1:0]   rm_leds = '0;
  logic               req_ready, done, active_valid, pr_start, decouple, rm_rst;
  logic [1:0]         err_code;
  logic [RM_ID_W-1:0] active_rm_id, pr_rm_id;
  logic [LED_W-1:0]   leds;

  dpr_region_ctrl #(
    .RM_ID_W(RM_ID_W), .LED_W(LED_W), .DECOUPLE_CYCLES(DEC),
    .RESET_CYCLES(RSTC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rm_id(req_rm_id),
    .req_ready(req_ready), .done(done), .err_code(err_code),
    .active_valid(active_valid), .active_rm_id(active_rm_id),
    .pr_start(pr_start), .pr_rm_id(pr_rm_id), .pr_done(pr_done),
    .pr_error(pr_error), .decouple(decouple), .rm_rst(rm_rst),
    .rm_leds(rm_leds), .leds(leds)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  bit rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int cyc; int err; int av; int id; int dec; int leds;
  } done_t;
  typedef struct {
    int cyc; int id;
  } pr_t;

  done_t done_q[$];
  pr_t   pr_q[$];
  done_t de;
  pr_t   pe;

  // Abstract model of the region: what is loaded, whether it is isolated, last error.
  bit m_valid  = 1'b0;
  int m_id     = 0;
  bit m_dec    = 1'b1;
  int m_err    = 0;
  int m_frozen = 0;

  function automatic int exp_leds(input bit dec, input int err, input int frozen);
`ifdef DPR_STATUS_LEDS_EN
    if (dec) return (1 << (LED_W - 1)) | err;
`endif
    return frozen;
  endfunction

  task automatic push_done(input int c, input int err, input int av, input int id,
                           input int dec, input int lv);
    done_t d;
    d.cyc = c; d.err = err; d.av = av; d.id = id; d.dec = dec; d.leds = lv;
    done_q.push_back(d);
  endtask

  task automatic push_pr(input int c, input int id);
    pr_t p;
    p.cyc = c; p.id = id;
    pr_q.push_back(p);
  endtask

  // Monitor: pops expected responses whenever the DUT presents done or pr_start.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL done_unexpected: done=1 at cycle %0d, expected no done", cyc);
      end else begin
        de = done_q.pop_front();
        chk("done_cycle", cyc, de.cyc);
        chk("done_err_code", err_code, de.err);
        chk("done_active_valid", active_valid, de.av);
        chk("done_active_rm_id", active_rm_id, de.id);
        chk("done_decouple", decouple, de.dec);
        chk("done_leds", leds, de.leds);
      end
    end
    if (pr_start === 1'b1) begin
      if (pr_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL pr_start_unexpected: pr_start=1 at cycle %0d, expected 0", cyc);
      end else begin
        pe = pr_q.pop_front();
        chk("pr_start_cycle", cyc, pe.cyc);
        chk("pr_rm_id", pr_rm_id, pe.id);
        chk("pr_start_decoupled", decouple, 1);
      end
    end
  end

  // Every rm_rst run after a reset edge or a load must last RESET_CYCLES.
  int rr_run = 0;
  always @(negedge clk) begin
    if (rst_seen) begin
      rr_run = (rm_rst === 1'b1) ? 1 : 0;
    end else if (rm_rst === 1'b1) begin
      rr_run++;
    end else if (rr_run != 0) begin
      chk("rm_rst_len", rr_run, RSTC);
      rr_run = 0;
    end
  end

  task automatic step();
    @(negedge clk);
    rm_leds = LED_W'($urandom);
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    ok = (req_ready === 1'b1);
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL wait_ready: req_ready=%0b after %0d cycles, expected 1", req_ready, n);
    end else begin
      chk("err_sticky", err_code, m_err);
    end
  endtask

  // mode: 0 loader ok, 1 pr_error, 2 pr_error+pr_done together, 3 loader silent
  task automatic run_req(input int id, input int mode, input int dly);
    int c, done_c, lv;
    bit ok, same;
    wait_ready(ok);
    if (!ok) return;
    c    = cyc;
    same = m_valid && (id == m_id);
    lv   = int'($urandom_range(0, 255));
    rm_leds   = LED_W'(lv);
    req_rm_id = RM_ID_W'(id);
    req_valid = 1'b1;
    if (!m_dec) m_frozen = lv;
    m_err = 0;
    if (same) begin
      done_c = c + 1;
      push_done(done_c, 0, 1, id, 0, exp_leds(1'b0, 0, m_frozen));
    end else begin
      push_pr(c + 1 + DEC, id);
      case (mode)
        0: begin
          done_c = c + 1 + DEC + dly + 1 + RSTC;
          m_valid = 1'b1; m_id = id; m_dec = 1'b0; m_err = 0;
        end
        1, 2: begin
          done_c = c + 1 + DEC + dly + 1;
          m_valid = 1'b0; m_dec = 1'b1; m_err = 1;
        end
        default: begin
          done_c = c + 1 + DEC + TMO;
          m_valid = 1'b0; m_dec = 1'b1; m_err = 2;
        end
      endcase
      push_done(done_c, m_err, int'(m_valid), m_id, int'(m_dec),
                exp_leds(m_dec, m_err, m_frozen));
    end
    step();
    req_valid = 1'b0;
    if (!same && mode != 3) begin
      while (cyc < c + 1 + DEC + dly) step();
      pr_done  = (mode == 0 || mode == 2);
      pr_error = (mode != 0);
      step();
      pr_done  = 1'b0;
      pr_error = 1'b0;
    end
    while (cyc <= done_c) step();
    lv = int'($urandom_range(0, 255));
    rm_leds = LED_W'(lv);
    @(negedge clk);
    if (m_valid) chk("leds_track", leds, lv);
    else         chk("leds_frozen_after_err", leds, exp_leds(1'b1, m_err, m_frozen));
  endtask

  task automatic stray_loader_pulse();
    pr_done  = $urandom_range(0, 1) == 1;
    pr_error = !pr_done;
    step();
    pr_done  = 1'b0;
    pr_error = 1'b0;
  endtask

  task automatic run_abort();
    int c, e, id, n, lv;
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    id = (m_id + 1 + int'($urandom_range(0, 13))) % 16;
    c  = cyc;
    lv = int'($urandom_range(0, 255));
    rm_leds   = LED_W'(lv);
    req_rm_id = RM_ID_W'(id);
    req_valid = 1'b1;
    push_pr(c + 1 + DEC, id);
    step();
    req_valid = 1'b0;
    while (cyc < c + 1 + DEC + 10) step();
    rst = 1'b1;
    step();
    e = cyc;
    chk("abort_rm_rst", rm_rst, 1);
    chk("abort_decouple", decouple, 1);
    chk("abort_active_valid", active_valid, 0);
    chk("abort_pr_start", pr_start, 0);
    chk("abort_req_ready", req_ready, 0);
    chk("abort_leds", leds, exp_leds(1'b1, 0, 0));
    rst = 1'b0;
    m_valid = 1'b1; m_id = 0; m_dec = 1'b0; m_err = 0; m_frozen = 0;
    n = 0;
    while (active_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("abort_release_cycle", cyc, e + RSTC);
    chk("abort_release_rm_id", active_rm_id, 0);
  endtask

  initial begin
    int n, id, mode, r;
    rst = 1'b1;
    step();
    chk("rst_decouple", decouple, 1);
    chk("rst_rm_rst", rm_rst, 1);
    chk("rst_pr_start", pr_start, 0);
    chk("rst_done", done, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_active_valid", active_valid, 0);
    chk("rst_active_rm_id", active_rm_id, 0);
    chk("rst_leds", leds, exp_leds(1'b1, 0, 0));
    step();
    step();
    rst = 1'b0;
    n = 0;
    while (decouple === 1'b1 && n < 40) begin
      n++;
      step();
    end
    chk("post_reset_decouple_len", n, RSTC);
    chk("post_reset_rm_rst", rm_rst, 0);
    chk("post_reset_active_valid", active_valid, 1);
    chk("post_reset_active_rm_id", active_rm_id, 0);
    m_valid = 1'b1; m_id = 0; m_dec = 1'b0; m_err = 0; m_frozen = 0;

    run_req(3, 0, 50);
    run_req(3, 0, 10);
    run_req(5, 2, 20);
    run_req(7, 3, 0);
    run_req(5, 0, 50);
    run_req(9, 0, 99);
    run_req(0, 1, 1);
    run_req(0, 0, 1);
    stray_loader_pulse();

    for (int i = 0; i < 20; i++) begin
      id   = ($urandom_range(0, 2) == 0) ? m_id : int'($urandom_range(0, 15));
      r    = int'($urandom_range(0, 9));
      mode = (r < 6) ? 0 : (r < 7) ? 1 : (r < 8) ? 2 : 3;
      if ($urandom_range(0, 3) == 0) stray_loader_pulse();
      run_req(id, mode, int'($urandom_range(1, 60)));
    end

    run_abort();
    run_req(0, 0, 5);
    run_req(6, 0, 5);

    repeat (5) step();
    chk("done_queue_empty", done_q.size(), 0);
    chk("pr_queue_empty", pr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
